// File: rtl/if_fetch_unit_if.sv
// Signal bundle between the fetch unit, instruction memory, the redirect source and the IF/ID register.
// The master modport is the fetch unit's view; the slave modport is the surrounding pipeline and memory.
interface if_fetch_unit_if #(
    parameter int unsigned PC_WIDTH    = 8,
    parameter int unsigned INSTR_WIDTH = 32
);
    logic                   imem_req_valid;
    logic                   imem_req_ready;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_rsp_valid;
    logic [INSTR_WIDTH-1:0] imem_rsp_data;
    logic                   redirect_valid;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic                   if_valid;
    logic                   if_ready;
    logic [PC_WIDTH-1:0]    if_pc;
    logic [INSTR_WIDTH-1:0] if_instr;

    modport master (
        output imem_req_valid, imem_addr, if_valid, if_pc, if_instr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, if_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, if_valid, if_pc, if_instr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, if_ready
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: in-order imem reads, tag FIFO for in-flight requests, output buffer to IF/ID.
// Redirects restart fetch and kill in-flight requests, whose late responses are then dropped.
module if_fetch_unit #(
    parameter int unsigned         PC_WIDTH    = 8,
    parameter int unsigned         INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int unsigned         DEPTH       = 2
) (
    input  logic           clock,
    input  logic           reset,
    if_fetch_unit_if.master bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
    } buf_entry_t;

    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_tag_pc [DEPTH];
    logic [DEPTH-1:0]    r_tag_live;
    logic [PTR_W-1:0]    r_tag_wptr;
    logic [PTR_W-1:0]    r_tag_rptr;
    logic [CNT_W-1:0]    r_inflight_cnt;
    buf_entry_t          r_buf [DEPTH];
    logic [PTR_W-1:0]    r_buf_wptr;
    logic [PTR_W-1:0]    r_buf_rptr;
    logic [CNT_W-1:0]    r_buf_cnt;

    logic [SUM_W-1:0]    w_occupancy;
    logic                w_req_valid;
    logic                w_req_fire;
    logic                w_rsp_fire;
    logic                w_buf_push;
    logic                w_buf_pop;
    logic                w_buf_nonempty;
    buf_entry_t          w_head;

    // Every slot is either awaiting a response or holding a word, so issue only while one is free.
    assign w_occupancy    = SUM_W'(r_inflight_cnt) + SUM_W'(r_buf_cnt);
    assign w_req_valid    = !reset && !bus.redirect_valid && (w_occupancy < SUM_W'(DEPTH));
    assign w_req_fire     = w_req_valid && bus.imem_req_ready;
    assign w_rsp_fire     = bus.imem_rsp_valid && (r_inflight_cnt != '0);
    assign w_buf_push     = w_rsp_fire && r_tag_live[r_tag_rptr] && !bus.redirect_valid;
    assign w_buf_nonempty = (r_buf_cnt != '0);
    assign w_buf_pop      = w_buf_nonempty && bus.if_ready && !bus.redirect_valid;
    assign w_head         = r_buf[r_buf_rptr];

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_addr      = r_pc;
    assign bus.if_valid       = w_buf_nonempty;
    assign bus.if_pc          = w_buf_nonempty ? w_head.pc    : '0;
    assign bus.if_instr       = w_buf_nonempty ? w_head.instr : '0;

    // Control state: PC, tag FIFO pointers/live bits, occupancy counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc           <= RESET_PC;
            r_tag_live     <= '0;
            r_tag_wptr     <= '0;
            r_tag_rptr     <= '0;
            r_inflight_cnt <= '0;
            r_buf_wptr     <= '0;
            r_buf_rptr     <= '0;
            r_buf_cnt      <= '0;
        end else begin
            if (bus.redirect_valid) begin
                r_pc <= bus.redirect_pc;
            end else if (w_req_fire) begin
                r_pc <= r_pc + PC_WIDTH'(4);
            end

            if (w_req_fire) begin
                r_tag_wptr <= r_tag_wptr + PTR_W'(1);
            end
            if (w_rsp_fire) begin
                r_tag_rptr <= r_tag_rptr + PTR_W'(1);
            end

            // Stale entries keep their slot but lose their live bit so the word is discarded.
            if (bus.redirect_valid) begin
                r_tag_live <= '0;
            end else if (w_req_fire) begin
                r_tag_live[r_tag_wptr] <= 1'b1;
            end

            case ({w_req_fire, w_rsp_fire})
                2'b10:   r_inflight_cnt <= r_inflight_cnt + CNT_W'(1);
                2'b01:   r_inflight_cnt <= r_inflight_cnt - CNT_W'(1);
                default: r_inflight_cnt <= r_inflight_cnt;
            endcase

            if (bus.redirect_valid) begin
                r_buf_cnt  <= '0;
                r_buf_wptr <= '0;
                r_buf_rptr <= '0;
            end else begin
                if (w_buf_push) begin
                    r_buf_wptr <= r_buf_wptr + PTR_W'(1);
                end
                if (w_buf_pop) begin
                    r_buf_rptr <= r_buf_rptr + PTR_W'(1);
                end
                case ({w_buf_push, w_buf_pop})
                    2'b10:   r_buf_cnt <= r_buf_cnt + CNT_W'(1);
                    2'b01:   r_buf_cnt <= r_buf_cnt - CNT_W'(1);
                    default: r_buf_cnt <= r_buf_cnt;
                endcase
            end
        end
    end

    // Payload storage needs no reset; entries are only read while counted valid.
    always_ff @(posedge clock) begin
        if (w_req_fire) begin
            r_tag_pc[r_tag_wptr] <= r_pc;
        end
        if (w_buf_push) begin
            r_buf[r_buf_wptr] <= '{pc: r_tag_pc[r_tag_rptr], instr: bus.imem_rsp_data};
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: in-order memory model returning data = address,
// steady fetch, decode stall, redirects, PC wrap and asynchronous reset.
module tb_if_fetch_unit;
    logic clock;
    logic reset;

    if_fetch_unit_if #(.PC_WIDTH(8), .INSTR_WIDTH(32)) bus ();

    if_fetch_unit #(
        .PC_WIDTH    (8),
        .INSTR_WIDTH (32),
        .RESET_PC    (8'h00),
        .DEPTH       (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         n_checks;
    int         n_fail;
    int         acc_count;
    logic       mem_hold;
    logic       rsp_seen;
    logic [7:0] pending [$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock: record an accepted request, then drive the oldest pending response one cycle later.
    task automatic step();
        #1;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            pending.push_back(bus.imem_addr);
            acc_count++;
        end
        @(posedge clock);
        #1;
        if (!mem_hold && pending.size() > 0) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = 32'(pending.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end
        #1;
    endtask

    // Wait (bounded) for the next output entry, check it, and consume it with if_ready=1.
    task automatic expect_next(input string tag, input logic [7:0] pc);
        int n;
        n = 0;
        while (!bus.if_valid && n < 12) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 32'(bus.if_valid), 32'd1);
        chk({tag, "_pc"},    32'(bus.if_pc),    32'(pc));
        chk({tag, "_instr"}, bus.if_instr,      32'(pc));
        step();
    endtask

    task automatic apply_reset();
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        mem_hold           = 1'b0;
        pending.delete();
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        n_checks           = 0;
        n_fail             = 0;
        acc_count          = 0;
        mem_hold           = 1'b0;
        rsp_seen           = 1'b0;
        reset              = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.if_ready       = 1'b1;

        step();
        step();
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_addr",      32'(bus.imem_addr),      32'h00);
        chk("rst_if_valid",  32'(bus.if_valid),       32'd0);
        chk("rst_if_pc",     32'(bus.if_pc),          32'h00);
        chk("rst_if_instr",  bus.if_instr,            32'h0);

        // Steady fetch from reset release.
        reset = 1'b0;
        #1;
        chk("t1_c0_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t1_c0_addr",      32'(bus.imem_addr),      32'h00);
        step();
        chk("t1_c1_if_valid",  32'(bus.if_valid),       32'd0);
        chk("t1_c1_addr",      32'(bus.imem_addr),      32'h04);
        step();
        chk("t1_c2_if_valid",  32'(bus.if_valid),       32'd1);
        expect_next("t1_o0", 8'h00);
        expect_next("t1_o1", 8'h04);
        expect_next("t1_o2", 8'h08);
        expect_next("t1_o3", 8'h0C);

        // Decode stall: two requests fill the slots, then fetch stops.
        apply_reset();
        bus.if_ready = 1'b0;
        acc_count    = 0;
        repeat (6) step();
        chk("t2_accepted",  32'(acc_count),          32'd2);
        chk("t2_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("t2_addr",      32'(bus.imem_addr),      32'h08);
        chk("t2_head_pc",   32'(bus.if_pc),          32'h00);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        chk("t2_spur_pc",    32'(bus.if_pc), 32'h00);
        chk("t2_spur_instr", bus.if_instr,   32'h0);
        bus.if_ready = 1'b1;
        expect_next("t2_d0", 8'h00);
        expect_next("t2_d1", 8'h04);
        expect_next("t2_d2", 8'h08);

        // Redirect with two requests outstanding: both responses dropped.
        apply_reset();
        mem_hold           = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h10;
        #1;
        chk("t3_redir_req_valid", 32'(bus.imem_req_valid), 32'd0);
        step();
        bus.redirect_valid = 1'b0;
        acc_count          = 0;
        #1;
        chk("t3_addr_10", 32'(bus.imem_addr), 32'h10);
        step();
        step();
        chk("t3_two_inflight", 32'(acc_count),          32'd2);
        chk("t3_full_req",     32'(bus.imem_req_valid), 32'd0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h40;
        step();
        bus.redirect_valid = 1'b0;
        mem_hold           = 1'b0;
        #1;
        chk("t3_addr_40",  32'(bus.imem_addr), 32'h40);
        chk("t3_if_valid", 32'(bus.if_valid),  32'd0);
        expect_next("t3_o0", 8'h40);
        expect_next("t3_o1", 8'h44);

        // Redirect in the same cycle as a response: the word is dropped.
        for (int i = 0; i < 10 && !bus.imem_rsp_valid; i++) step();
        rsp_seen           = bus.imem_rsp_valid;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h80;
        step();
        bus.redirect_valid = 1'b0;
        #1;
        chk("t4_rsp_seen", 32'(rsp_seen),      32'd1);
        chk("t4_if_valid", 32'(bus.if_valid),  32'd0);
        chk("t4_addr",     32'(bus.imem_addr), 32'h80);
        expect_next("t4_o0", 8'h80);

        // PC wraps modulo 256.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'hF8;
        step();
        bus.redirect_valid = 1'b0;
        expect_next("t5_o0", 8'hF8);
        expect_next("t5_o1", 8'hFC);
        expect_next("t5_o2", 8'h00);
        expect_next("t5_o3", 8'h04);

        // Asynchronous reset with a buffered word and a request in flight.
        apply_reset();
        bus.if_ready = 1'b0;
        step();
        step();
        chk("t6_pre_if_valid", 32'(bus.if_valid),  32'd1);
        chk("t6_pre_addr",     32'(bus.imem_addr), 32'h08);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_if_valid",  32'(bus.if_valid),       32'd0);
        chk("t6_async_if_pc",     32'(bus.if_pc),          32'h00);
        chk("t6_async_if_instr",  bus.if_instr,            32'h0);
        chk("t6_async_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("t6_async_addr",      32'(bus.imem_addr),      32'h00);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("t6_restart_req",  32'(bus.imem_req_valid), 32'd1);
        chk("t6_restart_addr", 32'(bus.imem_addr),      32'h00);
        bus.if_ready = 1'b1;
        expect_next("t6_o0", 8'h00);
        expect_next("t6_o1", 8'h04);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
